// File: rtl/risc16_mem_loader.sv
// rtl/risc16_mem_loader.sv - streams an image into RiSC16 memory while stalling the core
module risc16_mem_loader #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic [WORD_LENGTH-1:0] load_base,
  input  logic [WORD_LENGTH-1:0] load_count,
  input  logic [WORD_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] cpu_address,
  input  logic [WORD_LENGTH-1:0] cpu_dataIn,
  input  logic                   cpu_writeEn,
  output logic [WORD_LENGTH-1:0] mem_address,
  output logic [WORD_LENGTH-1:0] mem_dataIn,
  output logic                   mem_writeEn,
  output logic                   cpu_hold,
  output logic                   load_busy,
  output logic                   load_done,
  output logic [WORD_LENGTH-1:0] words_loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                 state;
  logic [WORD_LENGTH-1:0] ptr;
  logic [WORD_LENGTH-1:0] remaining;
  logic [WORD_LENGTH-1:0] wr_addr;
  logic [WORD_LENGTH-1:0] wr_data;
  logic                   wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      remaining    <= '0;
      words_loaded <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_en        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_en <= 1'b0;
          if (load_start) begin
            ptr          <= load_base;
            remaining    <= load_count;
            words_loaded <= '0;
            state        <= (load_count != '0) ? LOAD : DONE;
          end
        end
        LOAD: begin
          // Each accepted beat becomes a registered write presented in the next cycle.
          if (in_valid) begin
            wr_addr      <= ptr;
            wr_data      <= in_data;
            wr_en        <= 1'b1;
            ptr          <= ptr + WORD_LENGTH'(1);
            remaining    <= remaining - WORD_LENGTH'(1);
            words_loaded <= words_loaded + WORD_LENGTH'(1);
            if (remaining == WORD_LENGTH'(1)) state <= DONE;
          end else begin
            wr_en <= 1'b0;
          end
        end
        DONE: begin
          wr_en <= 1'b0;
          state <= IDLE;
        end
        default: begin
          wr_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign load_busy = (state == LOAD);
  assign load_done = (state == DONE);
  assign cpu_hold  = (state != IDLE);

  // Memory port is owned by the loader whenever the core is held.
  assign mem_address = cpu_hold ? wr_addr : cpu_address;
  assign mem_dataIn  = cpu_hold ? wr_data : cpu_dataIn;
  assign mem_writeEn = cpu_hold ? wr_en   : cpu_writeEn;

endmodule

// File: tb/tb_risc16_mem_loader.sv
// tb/tb_risc16_mem_loader.sv - self-checking bench for risc16_mem_loader
module tb_risc16_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [15:0] load_base;
  logic [15:0] load_count;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] cpu_address;
  logic [15:0] cpu_dataIn;
  logic        cpu_writeEn;
  logic [15:0] mem_address;
  logic [15:0] mem_dataIn;
  logic        mem_writeEn;
  logic        cpu_hold;
  logic        load_busy;
  logic        load_done;
  logic [15:0] words_loaded;

  risc16_mem_loader #(.WORD_LENGTH(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_count(load_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cpu_address(cpu_address), .cpu_dataIn(cpu_dataIn),
    .cpu_writeEn(cpu_writeEn), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_writeEn(mem_writeEn), .cpu_hold(cpu_hold), .load_busy(load_busy),
    .load_done(load_done), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] count;
    int          gap;
    logic [15:0] last_addr;
    logic [15:0] words;
  } vec_t;

  logic [15:0] mem [0:65535];
  wr_t         wlog[$];
  int          done_cnt;
  logic [15:0] dat [0:15];
  int          checks = 0;
  int          failures = 0;

  // Unified memory: captures on the falling edge while writeEn is high.
  always @(negedge clk) begin
    if (mem_writeEn === 1'b1) begin
      mem[mem_address] = mem_dataIn;
      wlog.push_back('{mem_address, mem_dataIn});
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one load of dat[0..count-1] with `gap` idle stream cycles between beats.
  task automatic run_load(input logic [15:0] base, input logic [15:0] count, input int gap);
    logic [15:0] exp_addr;
    wlog.delete();
    done_cnt   = 0;
    load_base  = base;
    load_count = count;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < int'(count); i++) begin
      check("in_ready_load", 32'(in_ready), 32'd1);
      check("hold_load", 32'(cpu_hold), 32'd1);
      check("busy_load", 32'(load_busy), 32'd1);
      in_valid = 1'b1;
      in_data  = dat[i];
      tick();
      in_valid = 1'b0;
      in_data  = 16'hBAD0;
      if (i != int'(count) - 1) begin
        for (int g = 0; g < gap; g++) begin
          check("in_ready_gap", 32'(in_ready), 32'd1);
          check("hold_gap", 32'(cpu_hold), 32'd1);
          if (g > 0) check("wen_gap", 32'(mem_writeEn), 32'd0);
          tick();
        end
      end
    end
    check("done_pulse", 32'(load_done), 32'd1);
    check("done_hold", 32'(cpu_hold), 32'd1);
    check("done_ready", 32'(in_ready), 32'd0);
    check("done_wen", 32'(mem_writeEn), 32'(count != 16'd0));
    tick();
    check("idle_done", 32'(load_done), 32'd0);
    check("idle_hold", 32'(cpu_hold), 32'd0);
    check("words_loaded", 32'(words_loaded), 32'(count));
    check("done_cnt", 32'(done_cnt), 32'd1);
    check("write_count", 32'(wlog.size()), 32'(count));
    exp_addr = base;
    for (int i = 0; i < int'(count) && i < wlog.size(); i++) begin
      check("wr_addr", 32'(wlog[i].a), 32'(exp_addr));
      check("wr_data", 32'(wlog[i].d), 32'(dat[i]));
      exp_addr = exp_addr + 16'd1;
    end
  endtask

  vec_t        vt[5];
  logic [15:0] saved;

  initial begin
    vt[0] = '{16'h0010, 16'd3, 0, 16'h0012, 16'd3};
    vt[1] = '{16'h0010, 16'd3, 2, 16'h0012, 16'd3};
    vt[2] = '{16'hFFFE, 16'd3, 0, 16'h0000, 16'd3};
    vt[3] = '{16'h0100, 16'd1, 1, 16'h0100, 16'd1};
    vt[4] = '{16'h0200, 16'd0, 0, 16'h0200, 16'd0};

    rst = 1'b1; load_start = 1'b0; load_base = '0; load_count = '0;
    in_data = '0; in_valid = 1'b0;
    cpu_address = 16'h1234; cpu_dataIn = 16'h5678; cpu_writeEn = 1'b0;
    done_cnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_pass_addr", 32'(mem_address), 32'h1234);
    check("rst_pass_data", 32'(mem_dataIn), 32'h5678);
    check("rst_pass_wen", 32'(mem_writeEn), 32'd0);

    // Table-driven loads
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 16; i++) dat[i] = 16'(16'h1111 * (i + 1) + t);
      run_load(vt[t].base, vt[t].count, vt[t].gap);
      check("tbl_words", 32'(words_loaded), 32'(vt[t].words));
      if (vt[t].count != 16'd0) begin
        check("tbl_last_addr", 32'(wlog[wlog.size()-1].a), 32'(vt[t].last_addr));
        cpu_address = vt[t].last_addr;
        #1;
        check("core_pass_addr", 32'(mem_address), 32'(vt[t].last_addr));
        check("core_read", 32'(mem[mem_address]), 32'(dat[vt[t].count - 1]));
      end
    end

    // Core writes are blocked during a load, pass through unchanged when idle.
    saved = mem[16'h0011];
    dat[0] = 16'h4242;
    load_base = 16'h0020; load_count = 16'd1; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    cpu_address = 16'h0011; cpu_dataIn = 16'hDEAD; cpu_writeEn = 1'b1;
    #1;
    check("blk_wen", 32'(mem_writeEn), 32'd0);
    check("blk_addr_not_cpu", 32'(mem_address != 16'h0011), 32'd1);
    tick();
    check("blk_wen2", 32'(mem_writeEn), 32'd0);
    in_valid = 1'b1; in_data = dat[0];
    tick();
    in_valid = 1'b0;
    check("blk_done_addr", 32'(mem_address), 32'h0020);
    check("blk_done_data", 32'(mem_dataIn), 32'h4242);
    cpu_writeEn = 1'b0;
    tick();
    check("blk_mem_kept", 32'(mem[16'h0011]), 32'(saved));
    check("blk_mem_load", 32'(mem[16'h0020]), 32'h4242);
    cpu_dataIn = 16'hBEEF; cpu_writeEn = 1'b1;
    #1;
    check("idle_pass_wen", 32'(mem_writeEn), 32'd1);
    check("idle_pass_addr", 32'(mem_address), 32'h0011);
    check("idle_pass_data", 32'(mem_dataIn), 32'hBEEF);
    tick();
    cpu_writeEn = 1'b0;
    check("idle_mem_write", 32'(mem[16'h0011]), 32'hBEEF);

    // Reset after 2 of 5 beats
    wlog.delete();
    for (int i = 0; i < 5; i++) dat[i] = 16'($urandom);
    load_base = 16'h0040; load_count = 16'd5; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = dat[i];
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_hold", 32'(cpu_hold), 32'd0);
    check("abort_busy", 32'(load_busy), 32'd0);
    check("abort_words", 32'(words_loaded), 32'd0);
    check("abort_wcount", 32'(wlog.size()), 32'd2);
    check("abort_mem0", 32'(mem[16'h0040]), 32'(dat[0]));
    check("abort_mem1", 32'(mem[16'h0041]), 32'(dat[1]));
    for (int i = 0; i < 5; i++) dat[i] = 16'($urandom);
    run_load(16'h0050, 16'd2, 0);

    // Randomized loads checked against the address/data model
    for (int r = 0; r < 10; r++) begin
      logic [15:0] b;
      logic [15:0] c;
      b = 16'($urandom);
      c = 16'($urandom_range(1, 8));
      for (int i = 0; i < 16; i++) dat[i] = 16'($urandom);
      run_load(b, c, int'($urandom_range(0, 2)));
      for (int i = 0; i < int'(c); i++)
        check("rand_mem", 32'(mem[16'(b + 16'(i))]), 32'(dat[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
